// File: rtl/seq_checker.sv
// +---------------------------------------------------------------------------+
// | seq_checker: locks onto an upstream 0->3->5->6->0 counter, flags           |
// | violations while locked and counts completed laps and errors.             |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module seq_checker #(
   parameter int LOCK_N = 2,
   parameter int LAP_W  = 8,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       seq_in,
   output logic             locked,
   output logic             err,
   output logic [LAP_W-1:0] lap_count,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      LOCKED = 2'd1,
      FAULT  = 2'd2
   } state_t;

   localparam logic [3:0]       c_lock_n  = 4'(LOCK_N);
   localparam logic [ERR_W-1:0] c_err_max = '1;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_match_cnt;
   logic [3:0] w_match_nxt;
   logic [2:0] r_prev;
   logic       r_prev_valid;
   logic [2:0] w_succ;
   logic       w_legal;
   logic       w_good;
   logic       w_bad;

   // Successor of the previously sampled code; illegal codes have none.
   always_comb begin
      w_succ  = 3'd0;
      w_legal = 1'b0;
      case (r_prev)
         3'd0:    begin w_succ = 3'd3; w_legal = 1'b1; end
         3'd3:    begin w_succ = 3'd5; w_legal = 1'b1; end
         3'd5:    begin w_succ = 3'd6; w_legal = 1'b1; end
         3'd6:    begin w_succ = 3'd0; w_legal = 1'b1; end
         default: begin w_succ = 3'd0; w_legal = 1'b0; end
      endcase
   end

   assign w_good = r_prev_valid & w_legal & (seq_in == w_succ);
   assign w_bad  = r_prev_valid & ~w_good;

   always_comb begin
      w_state_nxt = r_state;
      w_match_nxt = r_match_cnt;
      case (r_state)
         SEARCH: begin
            if (w_good) begin
               if ((r_match_cnt + 4'd1) >= c_lock_n) begin
                  w_state_nxt = LOCKED;
                  w_match_nxt = 4'd0;
               end else begin
                  w_match_nxt = r_match_cnt + 4'd1;
               end
            end else if (w_bad) begin
               w_match_nxt = 4'd0;
            end
         end
         LOCKED: begin
            w_match_nxt = 4'd0;
            if (w_bad) begin
               w_state_nxt = FAULT;
            end
         end
         FAULT: begin
            // The sample on the way out is judged as a first SEARCH sample.
            w_state_nxt = SEARCH;
            w_match_nxt = w_good ? 4'd1 : 4'd0;
         end
         default: begin
            w_state_nxt = SEARCH;
            w_match_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= SEARCH;
         r_match_cnt  <= 4'd0;
         r_prev       <= 3'd0;
         r_prev_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_match_cnt  <= w_match_nxt;
         r_prev       <= seq_in;
         r_prev_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         locked    <= 1'b0;
         err       <= 1'b0;
         lap_count <= '0;
         err_count <= '0;
      end else begin
         locked <= (w_state_nxt == LOCKED);
         err    <= (w_state_nxt == FAULT);
         if ((r_state == LOCKED) && w_good && (r_prev == 3'd6)) begin
            lap_count <= lap_count + LAP_W'(1);
         end
         if ((r_state == LOCKED) && w_bad && (err_count != c_err_max)) begin
            err_count <= err_count + ERR_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: two instances (default and LOCK_N=3/LAP_W=2/ERR_W=2)
// compared every cycle against a behavioural model, plus literal checks.
`default_nettype none

module tb_seq_checker;

   typedef struct {
      int st;      // 0 searching, 1 locked, 2 fault
      int match;
      int prev;
      bit pv;
      int lap;
      int errc;
   } mdl_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] seq_in = 3'd0;
   logic       locked_a, err_a, locked_b, err_b;
   logic [7:0] lap_a, errc_a;
   logic [1:0] lap_b, errc_b;

   int   n_cmp = 0;
   int   n_fail = 0;
   bit   cmp_en = 1'b0;
   int   last = 0;
   mdl_t ma, mb;

   always #5 clk = ~clk;

   seq_checker dut_a (
      .clk(clk), .reset(reset), .seq_in(seq_in),
      .locked(locked_a), .err(err_a), .lap_count(lap_a), .err_count(errc_a)
   );

   seq_checker #(.LOCK_N(3), .LAP_W(2), .ERR_W(2)) dut_b (
      .clk(clk), .reset(reset), .seq_in(seq_in),
      .locked(locked_b), .err(err_b), .lap_count(lap_b), .err_count(errc_b)
   );

   function automatic mdl_t mzero();
      mdl_t z;
      z.st = 0; z.match = 0; z.prev = 0; z.pv = 1'b0; z.lap = 0; z.errc = 0;
      return z;
   endfunction

   function automatic int succ(input int p);
      case (p)
         0: return 3;
         3: return 5;
         5: return 6;
         6: return 0;
         default: return -1;
      endcase
   endfunction

   function automatic mdl_t step(input mdl_t m, input int s, input int lock_n,
                                 input int lap_w, input int err_w);
      mdl_t r;
      bit   good, bad;
      r    = m;
      good = m.pv && (succ(m.prev) >= 0) && (s == succ(m.prev));
      bad  = m.pv && !good;
      r.prev = s;
      r.pv   = 1'b1;
      if (m.st == 1) begin
         if (good && m.prev == 6) r.lap = (m.lap + 1) % (1 << lap_w);
         if (bad) begin
            r.st   = 2;
            r.errc = (m.errc + 1 > (1 << err_w) - 1) ? m.errc : m.errc + 1;
         end
      end else if (m.st == 2) begin
         r.st    = 0;
         r.match = good ? 1 : 0;
      end else if (good) begin
         if (m.match + 1 >= lock_n) begin
            r.st = 1; r.match = 0;
         end else begin
            r.match = m.match + 1;
         end
      end else if (bad) begin
         r.match = 0;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("a_locked", int'(locked_a), int'(ma.st == 1));
         chk("a_err",    int'(err_a),    int'(ma.st == 2));
         chk("a_lap",    int'(lap_a),    ma.lap);
         chk("a_errcnt", int'(errc_a),   ma.errc);
         chk("b_locked", int'(locked_b), int'(mb.st == 1));
         chk("b_err",    int'(err_b),    int'(mb.st == 2));
         chk("b_lap",    int'(lap_b),    mb.lap);
         chk("b_errcnt", int'(errc_b),   mb.errc);
      end
   end

   // Called at posedge+1: drives a sample, advances the models at the edge.
   task automatic cycle(input int s);
      seq_in = 3'(s);
      last   = s;
      @(posedge clk);
      ma = step(ma, s, 2, 8, 8);
      mb = step(mb, s, 3, 2, 2);
      #1;
   endtask

   // Half-cycle asynchronous reset landing between clock edges.
   task automatic rst_pulse();
      #1;
      reset = 1'b0;
      ma = mzero();
      mb = mzero();
      #1;
      chk("rst_a_locked", int'(locked_a), 0);
      chk("rst_a_err",    int'(err_a),    0);
      chk("rst_a_lap",    int'(lap_a),    0);
      chk("rst_a_errcnt", int'(errc_a),   0);
      chk("rst_b_locked", int'(locked_b), 0);
      chk("rst_b_lap",    int'(lap_b),    0);
      chk("rst_b_errcnt", int'(errc_b),   0);
      #5;
      reset = 1'b1;
   endtask

   initial begin
      int lap_exp[5];
      int err_exp[5];
      lap_exp = '{1, 2, 3, 0, 1};
      err_exp = '{1, 2, 3, 3, 3};
      ma = mzero();
      mb = mzero();
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Lock, first lap.
      cycle(0); cycle(3); cycle(5);
      chk("lock_after_5", int'(locked_a), 1);
      chk("no_err_lock",  int'(err_a),    0);
      cycle(6); cycle(0);
      chk("first_lap", int'(lap_a), 1);

      // Held value while locked.
      cycle(3); cycle(5); cycle(5);
      chk("held_err",    int'(err_a),    1);
      chk("held_errcnt", int'(errc_a),   1);
      chk("held_unlock", int'(locked_a), 0);
      cycle(6);
      chk("err_one_cycle", int'(err_a), 0);
      cycle(0);
      chk("relock_held", int'(locked_a), 1);
      chk("no_lap_search", int'(lap_a), 1);

      // Illegal code while locked.
      cycle(3); cycle(5); cycle(6); cycle(0);
      chk("second_lap", int'(lap_a), 2);
      cycle(7);
      chk("illegal_err", int'(err_a),  1);
      chk("illegal_cnt", int'(errc_a), 2);
      cycle(0);
      cycle(3);
      chk("no_early_lock", int'(locked_a), 0);
      cycle(5);
      chk("relock_illegal", int'(locked_a), 1);

      // Lap wrap on the narrow instance.
      rst_pulse();
      cycle(0); cycle(3); cycle(5); cycle(6);
      chk("b_lock3", int'(locked_b), 1);
      for (int k = 0; k < 5; k++) begin
         cycle(0);
         chk("b_lap_wrap", int'(lap_b), lap_exp[k]);
         cycle(3); cycle(5); cycle(6);
      end

      // Error count saturation on the narrow instance.
      for (int k = 0; k < 5; k++) begin
         cycle(6);
         chk("b_err_pulse", int'(err_b),  1);
         chk("b_err_sat",   int'(errc_b), err_exp[k]);
         cycle(0); cycle(3); cycle(5); cycle(6);
      end

      // Reset while locked with lap_count=3, then relock.
      rst_pulse();
      cycle(0); cycle(3); cycle(5);
      for (int k = 0; k < 3; k++) begin
         cycle(6); cycle(0); cycle(3); cycle(5);
      end
      chk("lap3_locked", int'(lap_a), 3);
      rst_pulse();
      cycle(0); cycle(3); cycle(5);
      chk("relock_after_rst", int'(locked_a), 1);

      // Randomized traffic: mostly legal, some holds and random codes.
      for (int i = 0; i < 3000; i++) begin
         int r;
         int s;
         r = int'($urandom_range(0, 99));
         if (r < 82) s = (succ(last) >= 0) ? succ(last) : 0;
         else if (r < 90) s = last;
         else s = int'($urandom_range(0, 7));
         if ($urandom_range(0, 399) == 0) rst_pulse();
         cycle(s);
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
